// File: rtl/div_bus_sequencer.sv
// Serialises one 16/8 division request onto the divider's shared input bus and
// returns the captured remainder/quotient; zero divisors and divider hangs are answered locally.
module div_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [15:0] i_req_dividend,
  input  logic [7:0]  i_req_divisor,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [7:0]  o_rsp_quotient,
  output logic [7:0]  o_rsp_remainder,
  output logic        o_rsp_dbz,
  output logic        o_rsp_timeout,
  output logic        o_div_begin,
  output logic [7:0]  o_div_in_bus,
  input  logic        i_div_fin,
  input  logic [7:0]  i_div_out_bus,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRV_A, S_DRV_Q, S_DRV_M, S_WAIT_FIN, S_CAP_REM, S_CAP_QUO, S_RESP
  } state_t;

  localparam logic [7:0] LP_CNT_MAX = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_dvd_lo;
  logic [7:0] r_divisor;
  logic [7:0] r_cnt;
  logic       r_fin_q;
  logic       r_req_ready;
  logic       r_rsp_valid;
  logic [7:0] r_quo;
  logic [7:0] r_rem;
  logic       r_dbz;
  logic       r_to;
  logic       r_begin;
  logic [7:0] r_bus;
  logic       r_busy;

  logic w_accept;
  logic w_fin_rise;

  assign w_accept   = i_req_valid & r_req_ready;
  // Only a fresh edge counts: a fin level left over from the last job must not retrigger.
  assign w_fin_rise = i_div_fin & ~r_fin_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_dvd_lo    <= 8'h00;
      r_divisor   <= 8'h00;
      r_cnt       <= 8'h00;
      r_fin_q     <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_quo       <= 8'h00;
      r_rem       <= 8'h00;
      r_dbz       <= 1'b0;
      r_to        <= 1'b0;
      r_begin     <= 1'b0;
      r_bus       <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_fin_q <= i_div_fin;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dvd_lo    <= i_req_dividend[7:0];
            r_divisor   <= i_req_divisor;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (i_req_divisor == 8'h00) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_quo       <= 8'hFF;
              r_rem       <= i_req_dividend[7:0];
              r_dbz       <= 1'b1;
            end else begin
              r_state <= S_DRV_A;
              r_begin <= 1'b1;
              r_bus   <= i_req_dividend[15:8];
            end
          end
        end
        S_DRV_A: begin
          r_begin <= 1'b0;
          r_bus   <= r_dvd_lo;
          r_state <= S_DRV_Q;
        end
        S_DRV_Q: begin
          r_bus   <= r_divisor;
          r_state <= S_DRV_M;
        end
        S_DRV_M: begin
          r_bus   <= 8'h00;
          r_cnt   <= 8'h00;
          r_state <= S_WAIT_FIN;
        end
        S_WAIT_FIN: begin
          if (w_fin_rise) begin
            r_state <= S_CAP_REM;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_to        <= 1'b1;
            r_quo       <= 8'h00;
            r_rem       <= 8'h00;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_CAP_REM: begin
          r_rem   <= i_div_out_bus;
          r_state <= S_CAP_QUO;
        end
        S_CAP_QUO: begin
          r_quo       <= i_div_out_bus;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_dbz       <= 1'b0;
            r_to        <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_begin     <= 1'b0;
          r_bus       <= 8'h00;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_quotient  = r_quo;
  assign o_rsp_remainder = r_rem;
  assign o_rsp_dbz       = r_dbz;
  assign o_rsp_timeout   = r_to;
  assign o_div_begin     = r_begin;
  assign o_div_in_bus    = r_bus;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_div_bus_sequencer.sv
// Directed bench for div_bus_sequencer with a behavioural divider and a response scoreboard.
module tb_div_bus_sequencer;

  localparam int TMO = 16;

  logic        clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [15:0] i_req_dividend;
  logic [7:0]  i_req_divisor;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [7:0]  o_rsp_quotient;
  logic [7:0]  o_rsp_remainder;
  logic        o_rsp_dbz;
  logic        o_rsp_timeout;
  logic        o_div_begin;
  logic [7:0]  o_div_in_bus;
  logic        i_div_fin;
  logic [7:0]  i_div_out_bus;
  logic        o_busy;

  typedef struct packed {
    logic [7:0] quo;
    logic [7:0] rem;
    logic       dbz;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // divider model controls
  logic       m_hang = 1'b0;
  logic       m_sticky = 1'b0;
  int         m_lat = 2;

  div_bus_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_dividend(i_req_dividend), .i_req_divisor(i_req_divisor),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_quotient(o_rsp_quotient), .o_rsp_remainder(o_rsp_remainder),
    .o_rsp_dbz(o_rsp_dbz), .o_rsp_timeout(o_rsp_timeout),
    .o_div_begin(o_div_begin), .o_div_in_bus(o_div_in_bus),
    .i_div_fin(i_div_fin), .i_div_out_bus(i_div_out_bus),
    .o_busy(o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural divider: result computed from what actually arrived on the bus.
  initial begin : divider_model
    logic [7:0]  a, q, m;
    logic [15:0] dvd;
    i_div_fin     = 1'b0;
    i_div_out_bus = 8'h00;
    forever begin
      @(negedge clk);
      if (o_div_begin) begin
        a = o_div_in_bus;
        @(negedge clk);
        q = o_div_in_bus;
        @(negedge clk);
        m = o_div_in_bus;
        if (!m_hang) begin
          if (i_div_fin) begin
            i_div_out_bus = 8'hA5;
            repeat (m_lat) @(negedge clk);
            i_div_fin = 1'b0;
            @(negedge clk);
          end else begin
            repeat (m_lat) @(negedge clk);
          end
          dvd = {a, q};
          i_div_fin     = 1'b1;
          i_div_out_bus = 8'(dvd % {8'h00, m});
          @(negedge clk);
          @(negedge clk);
          i_div_out_bus = 8'(dvd / {8'h00, m});
          @(negedge clk);
          if (!m_sticky) i_div_fin = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] dvd, input logic [7:0] dvs, input logic exp_to);
    exp_t e;
    if (dvs == 8'h00)  e = '{quo: 8'hFF, rem: dvd[7:0], dbz: 1'b1, to: 1'b0};
    else if (exp_to)   e = '{quo: 8'h00, rem: 8'h00, dbz: 1'b0, to: 1'b1};
    else               e = '{quo: 8'(dvd / {8'h00, dvs}), rem: 8'(dvd % {8'h00, dvs}), dbz: 1'b0, to: 1'b0};
    sb.push_back(e);
    chk("req_ready_idle", {15'd0, o_req_ready}, 16'd1);
    i_req_valid    = 1'b1;
    i_req_dividend = dvd;
    i_req_divisor  = dvs;
    @(negedge clk);
    i_req_valid    = 1'b0;
  endtask

  task automatic wait_rsp(input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!o_rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrives", {15'd0, o_rsp_valid}, 16'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 16'd0, 16'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", {15'd0, o_rsp_valid}, 16'd1);
      chk("rsp_quo", {8'd0, o_rsp_quotient}, {8'd0, e.quo});
      chk("rsp_rem", {8'd0, o_rsp_remainder}, {8'd0, e.rem});
      chk("rsp_dbz", {15'd0, o_rsp_dbz}, {15'd0, e.dbz});
      chk("rsp_timeout", {15'd0, o_rsp_timeout}, {15'd0, e.to});
      chk("req_ready_resp", {15'd0, o_req_ready}, 16'd0);
      chk("busy_resp", {15'd0, o_busy}, 16'd1);
      if (i < hold) @(negedge clk);
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    chk("rsp_valid_drop", {15'd0, o_rsp_valid}, 16'd0);
    chk("req_ready_back", {15'd0, o_req_ready}, 16'd1);
    chk("busy_drop", {15'd0, o_busy}, 16'd0);
    chk("flags_clear", {14'd0, o_rsp_dbz, o_rsp_timeout}, 16'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {15'd0, o_req_ready}, 16'd1);
    chk({tag, "_valid"}, {15'd0, o_rsp_valid}, 16'd0);
    chk({tag, "_begin"}, {15'd0, o_div_begin}, 16'd0);
    chk({tag, "_bus"}, {8'd0, o_div_in_bus}, 16'd0);
    chk({tag, "_busy"}, {15'd0, o_busy}, 16'd0);
    chk({tag, "_quorem"}, {o_rsp_quotient, o_rsp_remainder}, 16'd0);
    chk({tag, "_flags"}, {14'd0, o_rsp_dbz, o_rsp_timeout}, 16'd0);
  endtask

  initial begin : stim
    int  n;
    logic seen;
    i_rst_n        = 1'b0;
    i_req_valid    = 1'b0;
    i_req_dividend = 16'h0000;
    i_req_divisor  = 8'h00;
    i_rsp_ready    = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    i_rst_n = 1'b1;
    @(negedge clk);

    // T1: bus sequence and nominal result
    m_lat = 2;
    send(16'h0064, 8'h07, 1'b0);
    chk("t1_begin_a", {15'd0, o_div_begin}, 16'd1);
    chk("t1_bus_a", {8'd0, o_div_in_bus}, 16'h0000);
    chk("t1_busy", {15'd0, o_busy}, 16'd1);
    @(negedge clk);
    chk("t1_begin_q", {15'd0, o_div_begin}, 16'd0);
    chk("t1_bus_q", {8'd0, o_div_in_bus}, 16'h0064);
    @(negedge clk);
    chk("t1_begin_m", {15'd0, o_div_begin}, 16'd0);
    chk("t1_bus_m", {8'd0, o_div_in_bus}, 16'h0007);
    @(negedge clk);
    chk("t1_bus_idle", {8'd0, o_div_in_bus}, 16'h0000);
    wait_rsp(0);

    // T2: divide by zero answered locally one cycle after accept
    send(16'h1234, 8'h00, 1'b0);
    chk("t2_valid_1cyc", {15'd0, o_rsp_valid}, 16'd1);
    chk("t2_no_begin", {15'd0, o_div_begin}, 16'd0);
    wait_rsp(0);

    // T3: divider never finishes
    m_hang = 1'b1;
    send(16'h0100, 8'h03, 1'b1);
    n = 0;
    while (!o_rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_latency", 16'(n), 16'(TMO + 3));
    wait_rsp(0);
    m_hang = 1'b0;
    send(16'h0100, 8'h03, 1'b0);
    wait_rsp(0);

    // T4: consumer stalls for 10 cycles
    m_lat = 5;
    send(16'd5000, 8'd77, 1'b0);
    wait_rsp(10);

    // T6: stale fin level across back-to-back jobs
    m_lat = 2;
    m_sticky = 1'b1;
    send(16'd200, 8'd9, 1'b0);
    wait_rsp(0);
    chk("t6_fin_left_high", {15'd0, i_div_fin}, 16'd1);
    m_sticky = 1'b0;
    m_lat = 3;
    send(16'd1000, 8'd33, 1'b0);
    wait_rsp(0);

    // T5: reset while waiting for fin
    m_hang = 1'b1;
    send(16'h0050, 8'h05, 1'b0);
    repeat (6) @(negedge clk);
    chk("t5_busy_before", {15'd0, o_busy}, 16'd1);
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_rst");
    sb.delete();
    @(negedge clk);
    i_rst_n = 1'b1;
    m_hang = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | o_rsp_valid;
    end
    chk("t5_no_rsp", {15'd0, seen}, 16'd0);
    m_lat = 1;
    send(16'd255, 8'd16, 1'b0);
    wait_rsp(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
